// File: rtl/prbs_gen_chk.sv
`default_nettype none
// ============================================================================
// Module  : prbs_gen_chk
// Brief   : PRBS7/15/23/31 word generator and self-synchronising checker with
//           HUNT/LOCKED framing and a saturating bit-error counter.
// Option  : PRBS_ERR_INJECT_EN adds input inj_err (flips gen_data bit 0 only).
// Rev     : 1.0  initial release
// ============================================================================
module prbs_gen_chk #(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 16,
    parameter int LOCK_CNT  = 32,
    parameter int LOSS_CNT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [1:0]           mode,
    output logic [DATA_W-1:0]    gen_data,
    output logic                 gen_valid,
    input  logic [DATA_W-1:0]    chk_data,
    input  logic                 chk_valid,
    input  logic                 err_clr,
`ifdef PRBS_ERR_INJECT_EN
    input  logic                 inj_err,
`endif
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int c_POP_W   = $clog2(DATA_W + 1);
    localparam int c_SUM_W   = ((ERR_CNT_W > c_POP_W) ? ERR_CNT_W : c_POP_W) + 1;
    localparam int c_RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    logic [1:0]           r_mode;
    logic [30:0]          r_lfsr;
    logic [DATA_W-1:0]    r_gen_data;
    logic                 r_gen_valid;
    logic [30:0]          r_hist;
    state_t               r_state;
    logic                 r_locked;
    logic [c_RUN_W-1:0]   r_good_cnt;
    logic [c_RUN_W-1:0]   r_bad_cnt;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_mode_chg;
    logic [4:0]           w_tap_a;
    logic [4:0]           w_tap_b;
    logic [30:0]          w_order_mask;
    logic [30:0]          w_lfsr_nxt;
    logic [DATA_W-1:0]    w_gen_word;
    logic [DATA_W-1:0]    w_out_word;
    logic [30:0]          w_hist_nxt;
    logic [DATA_W-1:0]    w_mis;
    logic [c_POP_W-1:0]   w_popcnt;
    logic                 w_hist_zero;
    logic                 w_word_err;
    logic                 w_cnt_inc;
    logic [c_SUM_W-1:0]   w_err_sum;
    logic [ERR_CNT_W-1:0] w_err_nxt;

    assign w_mode_chg = (mode != r_mode);

    // Tap positions are zero-based bit indices; tap_a-1 is also order-1.
    always_comb begin
        case (r_mode)
            2'b00: begin
                w_tap_a = 5'd6;
                w_tap_b = 5'd5;
            end
            2'b01: begin
                w_tap_a = 5'd14;
                w_tap_b = 5'd13;
            end
            2'b10: begin
                w_tap_a = 5'd22;
                w_tap_b = 5'd17;
            end
            default: begin
                w_tap_a = 5'd30;
                w_tap_b = 5'd27;
            end
        endcase
    end

    assign w_order_mask = {31{1'b1}} >> (5'd30 - w_tap_a);

    always_comb begin
        w_lfsr_nxt = r_lfsr;
        w_gen_word = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_gen_word[i] = w_lfsr_nxt[w_tap_a] ^ w_lfsr_nxt[w_tap_b];
            w_lfsr_nxt    = {w_lfsr_nxt[29:0], w_gen_word[i]};
        end
    end

`ifdef PRBS_ERR_INJECT_EN
    always_comb begin
        w_out_word    = w_gen_word;
        w_out_word[0] = w_gen_word[0] ^ inj_err;
    end
`else
    assign w_out_word = w_gen_word;
`endif

    // Each received bit is predicted from the bits received before it.
    always_comb begin
        w_hist_nxt = r_hist;
        w_mis      = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_mis[i]   = chk_data[i] ^ w_hist_nxt[w_tap_a] ^ w_hist_nxt[w_tap_b];
            w_hist_nxt = {w_hist_nxt[29:0], chk_data[i]};
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_popcnt = w_popcnt + c_POP_W'(w_mis[i]);
        end
    end

    // An all-zero stream predicts itself perfectly, so treat it as errored.
    assign w_hist_zero = ~|(r_hist & w_order_mask);
    assign w_word_err  = (|w_mis) | ((chk_data == '0) & w_hist_zero);

    assign w_cnt_inc = chk_valid & ~w_mode_chg & (r_state == ST_LOCKED);
    assign w_err_sum = c_SUM_W'(r_err_cnt) + c_SUM_W'(w_popcnt);
    assign w_err_nxt = (w_err_sum > c_SUM_W'({ERR_CNT_W{1'b1}})) ?
                       {ERR_CNT_W{1'b1}} : w_err_sum[ERR_CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= 2'b00;
            r_lfsr      <= '1;
            r_gen_data  <= '0;
            r_gen_valid <= 1'b0;
        end else if (w_mode_chg) begin
            r_mode      <= mode;
            r_lfsr      <= '1;
            r_gen_valid <= 1'b0;
        end else if (ena) begin
            r_lfsr      <= w_lfsr_nxt;
            r_gen_data  <= w_out_word;
            r_gen_valid <= 1'b1;
        end else begin
            r_gen_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist     <= '0;
            r_state    <= ST_HUNT;
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_err_cnt <= w_err_nxt;
            end

            if (w_mode_chg) begin
                r_state    <= ST_HUNT;
                r_locked   <= 1'b0;
                r_hist     <= '0;
                r_good_cnt <= '0;
                r_bad_cnt  <= '0;
            end else if (chk_valid) begin
                r_hist <= w_hist_nxt;
                case (r_state)
                    ST_HUNT: begin
                        if (w_word_err) begin
                            r_good_cnt <= '0;
                        end else if (r_good_cnt == c_RUN_W'(LOCK_CNT - 1)) begin
                            r_state    <= ST_LOCKED;
                            r_locked   <= 1'b1;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_good_cnt <= r_good_cnt + c_RUN_W'(1);
                        end
                    end
                    default: begin
                        if (!w_word_err) begin
                            r_bad_cnt <= '0;
                        end else if (r_bad_cnt == c_RUN_W'(LOSS_CNT - 1)) begin
                            r_state    <= ST_HUNT;
                            r_locked   <= 1'b0;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + c_RUN_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign gen_data  = r_gen_data;
    assign gen_valid = r_gen_valid;
    assign locked    = r_locked;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_gen_chk.sv
`default_nettype none
// ============================================================================
// Module  : tb_prbs_gen_chk
// Brief   : Randomised self-checking bench for prbs_gen_chk against a
//           bit-sequence reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_prbs_gen_chk;

    localparam int DW   = 8;
    localparam int EW   = 4;
    localparam int LOCK = 32;
    localparam int LOSS = 4;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] chk_data = '0;
    logic          chk_valid = 1'b0;
    logic          err_clr = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    logic          inj_err = 1'b0;
`endif
    wire  [DW-1:0] gen_data;
    wire           gen_valid;
    wire           locked;
    wire  [EW-1:0] err_cnt;
    wire  [DW+EW+1:0] dut_vec = {gen_valid, gen_data, locked, err_cnt};

    int total = 0;
    int bad   = 0;

    bit            loop_en = 1'b0;
    logic [DW-1:0] corrupt = '0;

    // Reference model: sequences kept as plain bit lists.
    bit            gq[$];
    bit            rq[$];
    logic [1:0]    m_mode;
    logic [DW-1:0] m_gdata;
    bit            m_gvalid;
    bit            m_locked;
    int            m_good;
    int            m_bad;
    int            m_err;

    prbs_gen_chk #(
        .DATA_W    (DW),
        .ERR_CNT_W (EW),
        .LOCK_CNT  (LOCK),
        .LOSS_CNT  (LOSS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (mode),
        .gen_data  (gen_data),
        .gen_valid (gen_valid),
        .chk_data  (chk_data),
        .chk_valid (chk_valid),
        .err_clr   (err_clr),
`ifdef PRBS_ERR_INJECT_EN
        .inj_err   (inj_err),
`endif
        .locked    (locked),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int tap_a(input logic [1:0] m);
        case (m)
            2'b00:   return 7;
            2'b01:   return 15;
            2'b10:   return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int tap_b(input logic [1:0] m);
        case (m)
            2'b00:   return 6;
            2'b01:   return 14;
            2'b10:   return 18;
            default: return 28;
        endcase
    endfunction

    function automatic void seed_gq();
        gq.delete();
        for (int k = 0; k < tap_a(m_mode); k++) gq.push_back(1'b1);
    endfunction

    function automatic void fill_rq();
        rq.delete();
        for (int k = 0; k < 31; k++) rq.push_back(1'b0);
    endfunction

    function automatic void m_reset();
        m_mode   = 2'b00;
        m_gdata  = '0;
        m_gvalid = 1'b0;
        m_locked = 1'b0;
        m_good   = 0;
        m_bad    = 0;
        m_err    = 0;
        seed_gq();
        fill_rq();
    endfunction

    function automatic void m_step(input bit en, input logic [1:0] md, input bit cv,
                                   input logic [DW-1:0] cd, input bit clr);
        bit            chg;
        bit            allz;
        bit            werr;
        bit            p;
        int            a;
        int            b;
        int            mis;
        logic [DW-1:0] w;
        chg  = (md != m_mode);
        a    = tap_a(m_mode);
        b    = tap_b(m_mode);
        mis  = 0;
        werr = 1'b0;
        if (!chg && cv) begin
            allz = 1'b1;
            for (int k = 1; k <= a; k++) if (rq[rq.size() - k]) allz = 1'b0;
            for (int i = DW - 1; i >= 0; i--) begin
                p = rq[rq.size() - a] ^ rq[rq.size() - b];
                if (cd[i] != p) mis++;
                rq.push_back(cd[i]);
            end
            while (rq.size() > 64) void'(rq.pop_front());
            werr = (mis != 0) || ((cd == '0) && allz);
        end
        if (clr) m_err = 0;
        else if (!chg && cv && m_locked) m_err = (m_err + mis > EMAX) ? EMAX : m_err + mis;
        if (chg) begin
            m_locked = 1'b0;
            m_good   = 0;
            m_bad    = 0;
            fill_rq();
        end else if (cv) begin
            if (!m_locked) begin
                m_bad = 0;
                if (werr) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == LOCK) begin
                        m_locked = 1'b1;
                        m_good   = 0;
                    end
                end
            end else begin
                m_good = 0;
                if (!werr) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad == LOSS) begin
                        m_locked = 1'b0;
                        m_bad    = 0;
                    end
                end
            end
        end
        if (chg) begin
            m_mode   = md;
            m_gvalid = 1'b0;
            seed_gq();
        end else if (en) begin
            w = '0;
            for (int i = DW - 1; i >= 0; i--) begin
                p    = gq[gq.size() - a] ^ gq[gq.size() - b];
                w[i] = p;
                gq.push_back(p);
            end
            while (gq.size() > 64) void'(gq.pop_front());
            m_gdata  = w;
            m_gvalid = 1'b1;
        end else begin
            m_gvalid = 1'b0;
        end
    endfunction

    function automatic logic [DW+EW+1:0] exp_vec();
        return {m_gvalid, m_gdata, m_locked, EW'(m_err)};
    endfunction

    task automatic tick();
        if (loop_en) begin
            chk_data  = m_gdata ^ corrupt;
            chk_valid = m_gvalid;
        end
        m_step(ena, mode, chk_valid, chk_data, err_clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; mode = 2'b00; chk_valid = 1'b1; chk_data = 8'hA5;
        err_clr = 1'b0; loop_en = 1'b0; corrupt = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_vec !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", dut_vec);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_word();
        tick();
        total++;
        if ({gen_valid, gen_data} !== {1'b1, 8'h02}) begin
            bad++; $display("FAIL first_word got=%b/%h exp=1/02", gen_valid, gen_data);
        end
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL first_word_model got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        loop_en = 1'b0;
        for (int n = 0; n < 400; n++) begin
            ena       = 1'($urandom_range(0, 1));
            chk_valid = 1'($urandom_range(0, 1));
            chk_data  = DW'($urandom);
            err_clr   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        mode = 2'b00; err_clr = 1'b0;
        tick();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL random_end got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_lock_prbs31();
        mode = 2'b11; ena = 1'b1; loop_en = 1'b1; corrupt = '0; err_clr = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL lock31 cyc=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        total++;
        if ({locked, err_cnt} !== {1'b1, 4'h0}) begin
            bad++; $display("FAIL lock31_final got=%b/%h exp=1/0", locked, err_cnt);
        end
    endtask

    task automatic relock(input logic [1:0] md, input string nm);
        mode = md; loop_en = 1'b1; corrupt = '0; ena = 1'b1; err_clr = 1'b0;
        tick();
        for (int n = 0; n < 200 && !m_locked; n++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL %s cyc=%0d got=%h exp=%h", nm, n, dut_vec, exp_vec());
            end
        end
        total++;
        if (locked !== 1'b1) begin
            bad++; $display("FAIL %s_locked got=%b exp=1", nm, locked);
        end
    endtask

    task automatic test_single_err();
        relock(2'b00, "lock7");
        corrupt = 8'h01;
        tick();
        corrupt = '0;
        repeat (3) tick();
        total++;
        if ({locked, err_cnt} !== {1'b1, 4'd3}) begin
            bad++; $display("FAIL single_err got=%b/%h exp=1/3", locked, err_cnt);
        end
    endtask

    task automatic test_loss();
        int e_saved;
        loop_en = 1'b0; chk_data = '0; chk_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL loss cyc=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        total++;
        if (locked !== 1'b0) begin
            bad++; $display("FAIL loss_unlocked got=%b exp=0", locked);
        end
        e_saved = m_err;
        repeat (6) tick();
        total++;
        if (err_cnt !== EW'(e_saved)) begin
            bad++; $display("FAIL hunt_no_count got=%h exp=%h", err_cnt, EW'(e_saved));
        end
    endtask

    task automatic test_saturate();
        relock(2'b00, "relock7");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        corrupt = 8'hFF;
        tick();
        tick();
        total++;
        if (err_cnt !== 4'hF) begin
            bad++; $display("FAIL sat_reach got=%h exp=f", err_cnt);
        end
        tick();
        total++;
        if ({locked, err_cnt} !== {1'b1, 4'hF}) begin
            bad++; $display("FAIL sat_hold got=%b/%h exp=1/f", locked, err_cnt);
        end
        err_clr = 1'b1;
        tick();
        total++;
        if ({locked, err_cnt} !== {1'b0, 4'h0}) begin
            bad++; $display("FAIL clr_wins got=%b/%h exp=0/0", locked, err_cnt);
        end
        err_clr = 1'b0; corrupt = '0;
        tick();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL sat_after got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_mode_change();
        relock(2'b11, "lock31b");
        corrupt = 8'h01;
        tick();
        corrupt = '0;
        repeat (6) tick();
        total++;
        if ({locked, err_cnt} !== {1'b1, 4'd3}) begin
            bad++; $display("FAIL err31 got=%b/%h exp=1/3", locked, err_cnt);
        end
        mode = 2'b01;
        tick();
        total++;
        if ({locked, gen_valid, err_cnt} !== {1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL mode_chg got=%b/%b/%h exp=0/0/3", locked, gen_valid, err_cnt);
        end
        relock(2'b01, "lock15");
        total++;
        if (err_cnt !== 4'd3) begin
            bad++; $display("FAIL lock15_err got=%h exp=3", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        loop_en = 1'b0;
        for (int n = 0; n < 20; n++) begin
            ena       = 1'($urandom_range(0, 1));
            chk_valid = 1'($urandom_range(0, 1));
            chk_data  = DW'($urandom);
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL pre_rst cyc=%0d got=%h exp=%h", n, dut_vec, exp_vec());
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        total++;
        if (dut_vec !== '0) begin
            bad++; $display("FAIL async_reset got=%h exp=0", dut_vec);
        end
        mode = 2'b00; ena = 1'b1; chk_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (dut_vec !== '0) begin
            bad++; $display("FAIL reset_hold got=%h exp=0", dut_vec);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if ({gen_valid, gen_data} !== {1'b1, 8'h02}) begin
            bad++; $display("FAIL reseed_word got=%b/%h exp=1/02", gen_valid, gen_data);
        end
        tick();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reseed_model got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_random();
        test_lock_prbs31();
        test_single_err();
        test_loss();
        test_saturate();
        test_mode_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits produced/checked per cycle, legal range 1..16.
REQ-002 SHALL have parameter ERR_CNT_W, default 16, error counter width.
REQ-003 SHALL have parameter LOCK_CNT, default 32, consecutive error-free words needed to lock.
REQ-004 SHALL have parameter LOSS_CNT, default 4, consecutive errored words needed to lose lock.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ena, input, 1, generator advance enable.
REQ-008 SHALL have port mode, input, 2, polynomial select: 00 PRBS7 (taps 7,6), 01 PRBS15 (15,14), 10 PRBS23 (23,18), 11 PRBS31 (31,28).
REQ-009 SHALL have port gen_data, output, DATA_W, generated word, MSB is the first-generated bit.
REQ-010 SHALL have port gen_valid, output, 1, gen_data is valid.
REQ-011 SHALL have port chk_data, input, DATA_W, received word, MSB first.
REQ-012 SHALL have port chk_valid, input, 1, chk_data is valid.
REQ-013 SHALL have port err_clr, input, 1, synchronous clear of err_cnt.
REQ-014 SHALL have port locked, output, 1, checker is in LOCKED.
REQ-015 SHALL have port err_cnt, output, ERR_CNT_W, saturating count of mismatched bits.

Function
REQ-016 Generator SHALL be a Fibonacci LFSR of the selected order N: fb = s[tapA-1] ^ s[tapB-1], next state = {s[N-2:0], fb}, and each output bit is fb.
REQ-017 On a cycle with ena=1 the generator SHALL advance DATA_W steps and register the DATA_W bits into gen_data, with gen_valid=1 on the following cycle (latency 1).
REQ-018 With ena=0, gen_data SHALL hold, gen_valid SHALL be 0, and the LFSR SHALL hold.
REQ-019 On any change of mode, the LFSR SHALL reseed to all-ones in the cycle after the change; gen_valid SHALL be 0 in that cycle regardless of ena.
REQ-020 Checker SHALL be self-synchronising: each received bit is predicted as h[tapA-1] ^ h[tapB-1] from a 31-bit history of prior received bits; the history shifts in received bits only on chk_valid=1.
REQ-021 A word is errored if any bit mismatches its prediction, or if both the word and the history bits [N-1:0] are all zero (stuck-at-0 guard).
REQ-022 The state machine SHALL have two states. HUNT moves to LOCKED after LOCK_CNT consecutive error-free valid words. LOCKED moves to HUNT after LOSS_CNT consecutive errored valid words. Both run-length counters reset on any opposite-type word.
REQ-023 locked SHALL be a registered output that asserts in the cycle after the transition.
REQ-024 In LOCKED only, err_cnt SHALL add the popcount of mismatched bits per valid word, saturating at all-ones with no wrap.
REQ-025 If err_clr and an increment occur in the same cycle, clear SHALL win and that cycle's increment SHALL be discarded.
REQ-026 A mode change SHALL force HUNT, clear the history and run-length counters, and preserve err_cnt.
REQ-027 chk_valid=0 SHALL leave all checker state unchanged.

Reset
REQ-028 While rst_n=0, outputs SHALL be: gen_data=0, gen_valid=0, locked=0, err_cnt=0.
REQ-029 While rst_n=0, internal state SHALL be: LFSR all-ones, history 0, state HUNT, run-length counters 0.
REQ-030 Reset SHALL take effect asynchronously mid-operation; the first advance after release uses the all-ones seed.

Configuration
REQ-031 With macro PRBS_ERR_INJECT_EN defined, the module SHALL add port inj_err (input, 1): on an ena cycle with inj_err=1, gen_data bit 0 is inverted in the output word only, and the LFSR sequence is unaffected.
REQ-032 Without PRBS_ERR_INJECT_EN, inj_err SHALL not exist and gen_data SHALL be the pure sequence.

Verification
REQ-033 Reset release, mode=00, DATA_W=8, ena=1 continuously -> first gen_valid word = 0x02.
REQ-034 gen_data looped to chk_data, mode=11 -> locked=1 exactly after the 32nd valid word, counted from the 32nd word after history fill; err_cnt stays 0 over 10000 words.
REQ-035 Loopback locked, PRBS_ERR_INJECT_EN defined, one inj_err pulse -> err_cnt = 3 (self-sync triplication, PRBS7) and locked stays 1.
REQ-036 Locked loopback, then chk_data forced to 0x00 -> locked=0 after 4 valid words; err_cnt stops incrementing in HUNT.
REQ-037 ERR_CNT_W=4, continuous corruption while locked -> err_cnt saturates at 0xF; err_clr asserted together with an error -> err_cnt=0 next cycle.
REQ-038 Mode changed 11->01 while locked -> next cycle locked=0, gen_valid=0, err_cnt preserved; relock on the PRBS15 sequence.
